// File: rtl/ripple_count_sequencer.sv
// Synchronous sequencer that clears an asynchronous ripple counter, issues count
// pulses, waits for the ripple to settle and checks each sample against a shadow count.
module ripple_count_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clk,
    output logic             cnt_rst,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] count_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CLEAR    = 3'd1,
        S_PULSE_HI = 3'd2,
        S_PULSE_LO = 3'd3,
        S_WAIT     = 3'd4,
        S_CHECK    = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state_r;
    logic [3:0]       wait_r;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] tgt_r;
    logic             cnt_clk_r;
    logic             cnt_rst_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [WIDTH-1:0] count_out_r;

    assign cnt_clk   = cnt_clk_r;
    assign cnt_rst   = cnt_rst_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign count_out = count_out_r;

    // Sequencer FSM; each output flop is loaded with its value for the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            wait_r      <= 4'd0;
            shadow_r    <= '0;
            tgt_r       <= '0;
            cnt_clk_r   <= 1'b0;
            cnt_rst_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            count_out_r <= '0;
        end else if (abort && (state_r != S_IDLE)) begin
            // Abort keeps err and count_out so the host can still inspect them.
            state_r   <= S_IDLE;
            cnt_clk_r <= 1'b0;
            cnt_rst_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        tgt_r     <= target;
                        err_r     <= 1'b0;
                        cnt_rst_r <= 1'b1;
                        busy_r    <= 1'b1;
                        state_r   <= S_CLEAR;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    shadow_r  <= '0;
                    cnt_rst_r <= 1'b0;
                    wait_r    <= 4'd0;
                    state_r   <= S_WAIT;
                end
                S_PULSE_HI: begin
                    cnt_clk_r <= 1'b0;
                    state_r   <= S_PULSE_LO;
                end
                S_PULSE_LO: begin
                    wait_r  <= 4'd0;
                    state_r <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_r == SETTLE_LAST) begin
                        state_r <= S_CHECK;
                    end else begin
                        wait_r  <= wait_r + 4'd1;
                        state_r <= S_WAIT;
                    end
                end
                S_CHECK: begin
                    count_out_r <= cnt_q;
                    if (cnt_q != shadow_r) begin
                        err_r   <= 1'b1;
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else if (shadow_r == tgt_r) begin
                        done_r  <= 1'b1;
                        state_r <= S_DONE;
                    end else begin
                        // Shadow advances with the pulse it predicts, so it never wraps.
                        shadow_r  <= shadow_r + WIDTH'(1);
                        cnt_clk_r <= 1'b1;
                        state_r   <= S_PULSE_HI;
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    cnt_clk_r <= 1'b0;
                    cnt_rst_r <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// Bench for ripple_count_sequencer: two instances (SETTLE=2 and SETTLE=1) each driving
// a behavioural ripple counter; expected results come from a scoreboard queue.
module tb_ripple_count_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] target = 4'd0;

    logic       cnt_clk_a, cnt_rst_a, busy_a, done_a, err_a;
    logic       cnt_clk_b, cnt_rst_b, busy_b, done_b, err_b;
    logic [3:0] count_out_a, count_out_b;
    logic [3:0] q_a = 4'd0;
    logic [3:0] q_b = 4'd0;
    logic [3:0] mask_a = 4'hf;
    logic [3:0] cnt_q_a, cnt_q_b;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int         lat;
        logic [3:0] cnt;
        logic       err;
        int         pulses;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ripple_count_sequencer #(.WIDTH(4), .SETTLE(2)) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
        .cnt_q(cnt_q_a), .cnt_clk(cnt_clk_a), .cnt_rst(cnt_rst_a), .busy(busy_a),
        .done(done_a), .err(err_a), .count_out(count_out_a)
    );

    ripple_count_sequencer #(.WIDTH(4), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .target(target),
        .cnt_q(cnt_q_b), .cnt_clk(cnt_clk_b), .cnt_rst(cnt_rst_b), .busy(busy_b),
        .done(done_b), .err(err_b), .count_out(count_out_b)
    );

    // Behavioural ripple counters; counter A can have bits forced to 0 by mask_a.
    always @(posedge cnt_clk_a or posedge cnt_rst_a or posedge rst)
        if (rst || cnt_rst_a) q_a <= 4'd0; else q_a <= q_a + 4'd1;
    always @(posedge cnt_clk_b or posedge cnt_rst_b or posedge rst)
        if (rst || cnt_rst_b) q_b <= 4'd0; else q_b <= q_b + 4'd1;
    assign cnt_q_a = q_a & mask_a;
    assign cnt_q_b = q_b;

    task automatic wait_idle();
        int n = 0;
        while ((busy_a || busy_b) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy_a || busy_b) begin
            failures++;
            $display("FAIL idle_timeout busy_a=%0b busy_b=%0b required 0", busy_a, busy_b);
        end
    endtask

    // Run one sequence on instance sel; poke pulses start while busy and during DONE.
    task automatic run_seq(input bit sel, input int tgt, input int s, input logic [3:0] mask, input bit poke);
        exp_t e;
        int first_done = -1, done_cnt = 0, pulses = 0, rst_cnt = 0, busy_bad = 0;
        logic d, b, ck, cr, er, err_at_done = 1'b0;
        logic [3:0] co, co_at_done = 4'd0;
        e.pulses = 0; e.err = 1'b0; e.cnt = 4'd0;
        for (int k = 0; k <= tgt; k++) begin
            logic [3:0] ob;
            ob = 4'(k) & mask;
            e.pulses = k;
            e.cnt = ob;
            if (ob != 4'(k)) begin
                e.err = 1'b1;
                break;
            end
        end
        e.lat = (s + 2) + e.pulses * (s + 3);
        sb.push_back(e);
        mask_a = sel ? 4'hf : mask;
        @(negedge clk);
        target = 4'(tgt);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        target = ~4'(tgt);
        for (int c = 0; c < 400; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            d  = sel ? done_b : done_a;
            b  = sel ? busy_b : busy_a;
            ck = sel ? cnt_clk_b : cnt_clk_a;
            cr = sel ? cnt_rst_b : cnt_rst_a;
            er = sel ? err_b : err_a;
            co = sel ? count_out_b : count_out_a;
            if (c == 1) begin
                checks++;
                if (er !== 1'b0) begin
                    failures++;
                    $display("FAIL err_clear_on_start got=%0b required 0", er);
                end
            end
            if (ck) pulses++;
            if (cr) rst_cnt++;
            if (d) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    err_at_done = er;
                    co_at_done = co;
                end
            end
            if (c >= 1 && (first_done < 0 || c == first_done) && b !== 1'b1) busy_bad++;
            if (first_done >= 0 && c > first_done && b !== 1'b0) busy_bad++;
            start = poke && (c == 5 || c == first_done);
            if (first_done >= 0 && c == first_done + 3) break;
        end
        start = 1'b0;
        e = sb.pop_front();
        checks++;
        if (first_done != e.lat) begin
            failures++;
            $display("FAIL done_latency t=%0d got=%0d required %0d", tgt, first_done, e.lat);
        end
        checks++;
        if (co_at_done !== e.cnt) begin
            failures++;
            $display("FAIL count_out t=%0d got=%0d required %0d", tgt, co_at_done, e.cnt);
        end
        checks++;
        if (err_at_done !== e.err) begin
            failures++;
            $display("FAIL err t=%0d got=%0b required %0b", tgt, err_at_done, e.err);
        end
        checks++;
        if (pulses != e.pulses) begin
            failures++;
            $display("FAIL pulse_count t=%0d got=%0d required %0d", tgt, pulses, e.pulses);
        end
        checks++;
        if (rst_cnt != 1 || done_cnt != 1) begin
            failures++;
            $display("FAIL clear_done_width t=%0d cnt_rst=%0d done=%0d required 1 1", tgt, rst_cnt, done_cnt);
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL busy_window t=%0d bad_cycles=%0d required 0", tgt, busy_bad);
        end
        wait_idle();
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({cnt_clk_a, cnt_rst_a, busy_a, done_a, err_a, count_out_a} !== 9'd0) begin
            failures++;
            $display("FAIL reset_a got=%b required 0", {cnt_clk_a, cnt_rst_a, busy_a, done_a, err_a, count_out_a});
        end
        checks++;
        if ({cnt_clk_b, cnt_rst_b, busy_b, done_b, err_b, count_out_b} !== 9'd0) begin
            failures++;
            $display("FAIL reset_b got=%b required 0", {cnt_clk_b, cnt_rst_b, busy_b, done_b, err_b, count_out_b});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        abort = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b0;
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_idle busy=%0b required 0", busy_a);
        end
    endtask

    task automatic test_basic();     run_seq(1'b0, 3, 2, 4'hf, 1'b0); endtask
    task automatic test_zero();      run_seq(1'b0, 0, 2, 4'hf, 1'b0); endtask
    task automatic test_max();       run_seq(1'b1, 15, 1, 4'hf, 1'b0); endtask
    task automatic test_busy_start(); run_seq(1'b0, 2, 2, 4'hf, 1'b1); endtask

    task automatic test_stuck();
        run_seq(1'b0, 5, 2, 4'b1101, 1'b0);
        run_seq(1'b0, 2, 2, 4'hf, 1'b0);
    endtask

    task automatic test_abort();
        int done_seen = 0;
        @(negedge clk);
        target = 4'd4;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        checks++;
        if ({busy_a, done_a, cnt_clk_a, cnt_rst_a} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_outputs busy/done/clk/rst=%b required 0000", {busy_a, done_a, cnt_clk_a, cnt_rst_a});
        end
        checks++;
        if (count_out_a !== 4'd1 || err_a !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold count_out=%0d err=%0b required 1 0", count_out_a, err_a);
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (done_a || busy_a) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            failures++;
            $display("FAIL abort_no_done active_cycles=%0d required 0", done_seen);
        end
        wait_idle();
        run_seq(1'b0, 4, 2, 4'hf, 1'b0);
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        target = 4'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
        end
        checks++;
        if (cnt_clk_a !== 1'b1) begin
            failures++;
            $display("FAIL pulse_hi_reached cnt_clk=%0b required 1", cnt_clk_a);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({cnt_clk_a, cnt_rst_a, busy_a, done_a, err_a, count_out_a} !== 9'd0) begin
            failures++;
            $display("FAIL rst_mid_async got=%b required 0", {cnt_clk_a, cnt_rst_a, busy_a, done_a, err_a, count_out_a});
        end
        @(negedge clk);
        rst = 1'b0;
        run_seq(1'b0, 3, 2, 4'hf, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_stuck();
        test_abort();
        test_busy_start();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
